// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath controls.
// Define CU_JAL_EN to make JAL (opcode 1101111) legal; otherwise it traps as an illegal opcode.
module multicycle_control_unit #(
   parameter int ALU_OP_W     = 4,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         instr,
   input  logic                mem_ready,
   input  logic                zero,
   output logic                pc_write,
   output logic                pc_src,
   output logic                ir_write,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                reg_write,
   output logic                mem_to_reg,
   output logic [1:0]          alu_a_sel,
   output logic [1:0]          alu_b_sel,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [2:0]          state,
   output logic                trap,
   output logic [1:0]          trap_cause
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_JUMP   = 3'd5,
      S_TRAP   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL
   } cls_t;

   localparam logic [7:0] WAIT_MAX  = 8'(MEM_WAIT_MAX);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef CU_JAL_EN
   localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

   state_t     cur;
   cls_t       cls;
   logic [7:0] wait_cnt;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;
   logic       dec_legal;
   cls_t       dec_cls;
   logic [3:0] op4;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7_b5   = instr[30];
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
   assign state       = cur;
   assign alu_op      = ALU_OP_W'(op4);

   always_comb begin
      dec_legal = 1'b1;
      dec_cls   = CLS_R;
      case (opcode)
         OP_R:      dec_cls = CLS_R;
         OP_I:      dec_cls = CLS_I;
         OP_LOAD:   dec_cls = CLS_LOAD;
         OP_STORE:  dec_cls = CLS_STORE;
         OP_BRANCH: dec_cls = CLS_BRANCH;
`ifdef CU_JAL_EN
         OP_JAL:    dec_cls = CLS_JAL;
`endif
         default:   dec_legal = 1'b0;
      endcase
   end

   // wait_cnt is zero outside FETCH/MEM because both states clear it on every exit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur        <= S_FETCH;
         cls        <= CLS_R;
         wait_cnt   <= 8'd0;
         trap       <= 1'b0;
         trap_cause <= 2'b00;
      end else begin
         case (cur)
            S_FETCH, S_MEM: begin
               if (mem_ready) begin
                  wait_cnt <= 8'd0;
                  if (cur == S_FETCH)
                     cur <= S_DECODE;
                  else
                     cur <= (cls == CLS_LOAD) ? S_WB : S_FETCH;
               end else if (wait_cnt == WAIT_MAX) begin
                  wait_cnt   <= 8'd0;
                  cur        <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= 2'b10;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DECODE: begin
               if (dec_legal) begin
                  cls <= dec_cls;
                  cur <= S_EXEC;
               end else begin
                  cur        <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= 2'b01;
               end
            end
            S_EXEC: begin
               case (cls)
                  CLS_R, CLS_I:        cur <= S_WB;
                  CLS_LOAD, CLS_STORE: cur <= S_MEM;
                  CLS_BRANCH: begin
                     if (funct3[2:1] == 2'b00) begin
                        cur <= S_FETCH;
                     end else begin
                        cur        <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'b01;
                     end
                  end
`ifdef CU_JAL_EN
                  CLS_JAL:             cur <= S_JUMP;
`endif
                  default:             cur <= S_FETCH;
               endcase
            end
            S_WB:    cur <= S_FETCH;
`ifdef CU_JAL_EN
            S_JUMP:  cur <= S_FETCH;
`endif
            S_TRAP:  cur <= S_TRAP;
            default: cur <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_a_sel  = 2'b00;
      alu_b_sel  = 2'b00;
      op4        = 4'b0000;
      case (cur)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_a_sel = 2'b01;
            alu_b_sel = 2'b10;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            // old PC + imm lands in ALU-out as the branch target
            alu_a_sel = 2'b10;
            alu_b_sel = 2'b01;
         end
         S_EXEC: begin
            case (cls)
               CLS_R: op4 = {funct7_b5, funct3};
               CLS_I: begin
                  alu_b_sel = 2'b01;
                  op4       = {(funct3 == 3'b101) & funct7_b5, funct3};
               end
               CLS_LOAD, CLS_STORE: alu_b_sel = 2'b01;
               CLS_BRANCH: begin
                  op4    = 4'b1000;
                  pc_src = 1'b1;
                  case (funct3)
                     3'b000:  pc_write = zero;
                     3'b001:  pc_write = !zero;
                     default: pc_write = 1'b0;
                  endcase
               end
`ifdef CU_JAL_EN
               CLS_JAL: begin
                  alu_a_sel = 2'b10;
                  alu_b_sel = 2'b10;
                  reg_write = 1'b1;
               end
`endif
               default: ;
            endcase
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = (cls == CLS_LOAD);
            mem_write = (cls == CLS_STORE);
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (cls == CLS_LOAD);
         end
`ifdef CU_JAL_EN
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
         end
`endif
         default: ;
      endcase
      if (!rst_n) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed test-plan steps, then random instructions
// checked cycle by cycle against a per-class expectation model.
module tb_multicycle_control_unit;

   localparam int MAXW = 15;
   localparam logic [7:0] PCW = 8'h80, PCS = 8'h40, IRW = 8'h20, IOD = 8'h10;
   localparam logic [7:0] MRD = 8'h08, MWR = 8'h04, RGW = 8'h02, M2R = 8'h01;
   localparam logic [7:0] STROBES = 8'hAE;
   localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_ILL = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        mem_ready = 1'b0;
   logic        zero = 1'b0;
   logic        pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg;
   logic [1:0]  alu_a_sel, alu_b_sel, trap_cause;
   logic [3:0]  alu_op;
   logic [2:0]  state;
   logic        trap;
   logic        trapped;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.ALU_OP_W(4), .MEM_WAIT_MAX(MAXW)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .zero(zero),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
      .alu_op(alu_op), .state(state), .trap(trap), .trap_cause(trap_cause)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int classify(input logic [6:0] o);
      case (o)
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b0000011: return C_LD;
         7'b0100011: return C_ST;
         7'b1100011: return C_BR;
`ifdef CU_JAL_EN
         7'b1101111: return C_JAL;
`endif
         default:    return C_ILL;
      endcase
   endfunction

   // st < 0 skips the state comparison; care masks select the fields defined in that cycle.
   task automatic expect_cycle(input string tag, input int st, input logic [7:0] en,
                               input logic [7:0] en_care, input logic [7:0] alu,
                               input logic [7:0] alu_care, input logic [2:0] tr);
      logic [7:0] got_en, got_alu;
      #2;
      got_en  = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg};
      got_alu = {alu_a_sel, alu_b_sel, alu_op};
      if (st >= 0) check({tag, " state"}, 32'(state), 32'(st));
      check({tag, " enables"}, 32'(got_en & en_care), 32'(en & en_care));
      check({tag, " alu"}, 32'(got_alu & alu_care), 32'(alu & alu_care));
      check({tag, " trap"}, 32'({trap, trap_cause}), 32'(tr));
   endtask

   task automatic expect_trap(input logic [1:0] cause);
      for (int i = 0; i < 2; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         zero      = 1'($urandom_range(0, 1));
         expect_cycle("trap", 7, 8'h00, STROBES, 8'h00, 8'h00, {1'b1, cause});
         tick();
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         #2;
         check("in_reset strobes",
               32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'd0);
         tick();
      end
      rst_n = 1'b0;
      check("post_reset state", 32'(state), 32'd0);
      check("post_reset trap", 32'({trap, trap_cause}), 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic do_wb(input logic is_load);
      mem_ready = 1'($urandom_range(0, 1));
      expect_cycle("wb", 4, RGW | (is_load ? M2R : 8'h00), STROBES | M2R, 8'h00, 8'h00, 3'b000);
      tick();
   endtask

   // wf/wm: wait cycles before mem_ready in FETCH/MEM (above MAXW means never ready).
   // rst_mem: MEM cycle index where rst_n is pulsed low (-1 for none).
   task automatic run_instr(input logic [31:0] ins, input int wf, input int wm,
                            input logic z, input int rst_mem, output logic tr);
      logic [2:0] f3;
      logic       f7b, rdy, take;
      int         cls;
      f3  = ins[14:12];
      f7b = ins[30];
      cls = classify(ins[6:0]);
      tr  = 1'b0;
      for (int i = 0; i <= wf && i <= MAXW; i++) begin
         rdy       = (i == wf);
         instr     = $urandom;
         mem_ready = rdy;
         zero      = 1'($urandom_range(0, 1));
         expect_cycle("fetch", 0, rdy ? (PCW | IRW | MRD) : MRD,
                      STROBES | IOD | (rdy ? PCS : 8'h00), {2'b01, 2'b10, 4'h0}, 8'hFF, 3'b000);
         tick();
      end
      if (wf > MAXW) begin
         expect_trap(2'b10);
         tr = 1'b1;
         return;
      end
      instr     = ins;
      mem_ready = 1'($urandom_range(0, 1));
      zero      = 1'($urandom_range(0, 1));
      expect_cycle("decode", 1, 8'h00, STROBES, {2'b10, 2'b01, 4'h0}, 8'hFF, 3'b000);
      tick();
      if (cls == C_ILL) begin
         expect_trap(2'b01);
         tr = 1'b1;
         return;
      end
      mem_ready = 1'($urandom_range(0, 1));
      zero      = z;
      case (cls)
         C_R: begin
            expect_cycle("exec_r", 2, 8'h00, STROBES, {2'b00, 2'b00, f7b, f3}, 8'hFF, 3'b000);
            tick();
            do_wb(1'b0);
         end
         C_I: begin
            expect_cycle("exec_i", 2, 8'h00, STROBES, {2'b00, 2'b01, (f3 == 3'd5) & f7b, f3},
                         8'h3F, 3'b000);
            tick();
            do_wb(1'b0);
         end
         C_LD, C_ST: begin
            expect_cycle("exec_ls", 2, 8'h00, STROBES, {2'b00, 2'b01, 4'h0}, 8'hFF, 3'b000);
            tick();
            for (int i = 0; i <= wm && i <= MAXW; i++) begin
               if (i == rst_mem) begin
                  mem_ready = 1'b0;
                  rst_n     = 1'b0;
                  expect_cycle("mem_rst", 3, 8'h00, STROBES, 8'h00, 8'h00, 3'b000);
                  tick();
                  rst_n = 1'b1;
                  return;
               end
               rdy       = (i == wm);
               mem_ready = rdy;
               expect_cycle("mem", 3, IOD | ((cls == C_LD) ? MRD : MWR), STROBES | IOD,
                            8'h00, 8'h00, 3'b000);
               tick();
            end
            if (wm > MAXW) begin
               expect_trap(2'b10);
               tr = 1'b1;
               return;
            end
            if (cls == C_LD) do_wb(1'b1);
         end
         C_BR: begin
            take = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
            expect_cycle("exec_br", 2, take ? (PCW | PCS) : PCS, STROBES | PCS,
                         {2'b00, 2'b00, 4'b1000}, 8'hFF, 3'b000);
            tick();
            if (f3 > 3'd1) begin
               expect_trap(2'b01);
               tr = 1'b1;
            end
         end
`ifdef CU_JAL_EN
         C_JAL: begin
            expect_cycle("exec_jal", 2, RGW, STROBES | M2R, {2'b10, 2'b10, 4'h0}, 8'hFF, 3'b000);
            tick();
            expect_cycle("jump", -1, PCW | PCS, STROBES | PCS, 8'h00, 8'h00, 3'b000);
            tick();
         end
`endif
         default: ;
      endcase
   endtask

   function automatic int pick_wait();
      int k;
      k = $urandom_range(0, 19);
      if (k < 12) return 0;
      if (k < 18) return $urandom_range(1, 3);
      if (k == 18) return MAXW;
      return MAXW + 1;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 7))
         0:       r[6:0] = 7'b0110011;
         1:       r[6:0] = 7'b0010011;
         2:       r[6:0] = 7'b0000011;
         3:       r[6:0] = 7'b0100011;
         4, 5: begin
            r[6:0]   = 7'b1100011;
            r[14:12] = 3'($urandom_range(0, 2));
         end
         6:       r[6:0] = 7'b1101111;
         default: r[6:0] = 7'($urandom);
      endcase
      return r;
   endfunction

   initial begin
      do_reset(2);
      // test-plan directed steps
      run_instr(32'h002081B3, 0, 0, 1'b0, -1, trapped);       // ADD
      run_instr(32'h402081B3, 0, 0, 1'b1, -1, trapped);       // SUB
      run_instr(32'h4020D193, 0, 0, 1'b0, -1, trapped);       // SRAI
      run_instr(32'h0000A183, 0, 3, 1'b0, -1, trapped);       // LW, 3 wait cycles
      run_instr(32'h00208063, 0, 0, 1'b1, -1, trapped);       // BEQ taken
      run_instr(32'h00209063, 0, 0, 1'b1, -1, trapped);       // BNE not taken
      run_instr(32'h0020A023, MAXW, MAXW, 1'b0, -1, trapped); // SW, ready on last allowed cycle
      run_instr(32'h0000007F, 0, 0, 1'b0, -1, trapped);       // illegal opcode
      check("illegal trapped", 32'(trapped), 32'd1);
      do_reset(1);
      run_instr(32'h002081B3, MAXW + 1, 0, 1'b0, -1, trapped); // fetch timeout
      check("fetch timeout trapped", 32'(trapped), 32'd1);
      do_reset(1);
      run_instr(32'h0000A183, 0, MAXW + 1, 1'b0, -1, trapped); // load timeout
      do_reset(1);
      run_instr(32'h0020A023, 0, 3, 1'b0, 1, trapped);        // reset during store MEM
      run_instr(32'h00209063, 0, 0, 1'b0, -1, trapped);       // BNE taken after abort
      // randomized instruction stream
      for (int n = 0; n < 150; n++) begin
         run_instr(rand_instr(), pick_wait(), pick_wait(), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0) ? 0 : -1, trapped);
         if (trapped) do_reset(1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle RV32I control FSM that replaces the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and writeback over several clocks, and drives the datapath enables, muxes and ALU operation. It handshakes with a shared instruction/data memory through `mem_ready` and traps on illegal opcodes or memory timeouts. It sits between the instruction register and the datapath; the PC, IR, old-PC and ALU-out registers live in the datapath.

## Interface
- `ALU_OP_W`, default 4: alu_op width (≥4); upper bits are zero-filled.
- `MEM_WAIT_MAX`, default 15: maximum wait cycles for `mem_ready` before a timeout trap (1..255).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `instr` in 32: IR contents; stable from DECODE onward.
- `mem_ready` in 1: memory access complete this cycle.
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: PC load enable.
- `pc_src` out 1: 0 = ALU result, 1 = ALU-out register (branch target).
- `ir_write` out 1: IR and old-PC load enable.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALU-out.
- `mem_read`, `mem_write` out 1: memory strobes, held until `mem_ready`.
- `reg_write` out 1: register file write.
- `mem_to_reg` out 1: writeback select; 1 = memory data.
- `alu_a_sel` out 2: 00 = rs1, 01 = PC, 10 = old PC.
- `alu_b_sel` out 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op` out `ALU_OP_W`: ALU operation.
- `state` out 3: current state, for debug.
- `trap` out 1: sticky fault flag.
- `trap_cause` out 2: 01 = illegal opcode, 10 = memory timeout.

## Operation
- State encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.
- **FETCH**
  - Drives `mem_read = 1`, `i_or_d = 0`, `alu_a_sel = 01`, `alu_b_sel = 10`, alu_op ADD.
  - On `mem_ready`: pulses `ir_write` and `pc_write` (`pc_src = 0`), then goes to DECODE.
- **DECODE**
  - Drives `alu_a_sel = 10`, `alu_b_sel = 01`, alu_op ADD, which computes the branch target into ALU-out.
  - Latches the opcode class in an internal register.
  - Supported opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - Any other opcode goes to TRAP with cause 01.
- **EXEC**
  - R: `alu_a_sel = 00`, `alu_b_sel = 00`, `alu_op = {funct7[5], funct3}`. Next: WB.
  - I-ALU: `alu_b_sel = 01`, `alu_op = {funct3 == 101 ? funct7[5] : 0, funct3}`. Next: WB.
  - LOAD/STORE: rs1 + imm, alu_op ADD (0000). Next: MEM.
  - BRANCH: rs1 − rs2, alu_op SUB (1000), `pc_src = 1`. Next: FETCH.
    - funct3 000 (BEQ): `pc_write = zero`.
    - funct3 001 (BNE): `pc_write = !zero`.
    - Other funct3 values trap with cause 01.
- **MEM**
  - Drives `i_or_d = 1`; `mem_read` for LOAD, `mem_write` for STORE.
  - On `mem_ready`: LOAD goes to WB, STORE goes to FETCH.
- **WB**
  - Pulses `reg_write`; `mem_to_reg = 1` for LOAD, 0 otherwise. Next: FETCH.
- **TRAP**
  - All enables and strobes are 0; `trap = 1`.
  - Held until reset.
- **Wait counter**
  - 8-bit counter, cleared on entry to FETCH or MEM and incremented on each cycle without `mem_ready`.
  - If the count equals `MEM_WAIT_MAX` with `mem_ready` still low, the next state is TRAP with cause 10.
  - `mem_ready` arriving on that same cycle wins; no trap.

## Timing
- Reset values (`rst_n` low at a clock edge): state = FETCH, wait counter = 0, `trap = 0`, `trap_cause = 00`.
- While `rst_n` is low, all write enables and strobes are forced to 0 combinationally.
- Reset mid-instruction aborts it; no partial writeback.
- Outputs are combinational from state, the latched class, `instr`, `mem_ready` and `zero`. The state register updates on the rising edge of `clk`.
- Latency with a zero-wait memory (`mem_ready` high in the first cycle):
  - BRANCH: 3 cycles.
  - R, I-ALU, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle adds 1.
- A memory request stays asserted, with constant address select, until `mem_ready` arrives.
- `ir_write` and `pc_write` are single-cycle pulses, coincident with `mem_ready` in FETCH.

## Configuration
- `CU_JAL_EN` defined:
  - Opcode 1101111 (JAL) is legal.
  - EXEC writes the link: `alu_a_sel = 10`, `alu_b_sel = 10`, ADD, `reg_write = 1`, `mem_to_reg = 0`.
  - Then a one-cycle jump: `pc_write = 1`, `pc_src = 1`. Next: FETCH.
  - JAL takes 4 cycles.
- `CU_JAL_EN` undefined:
  - 1101111 is illegal and traps with cause 01.

## Test plan
- **R-type:** ADD x3,x1,x2 (0x002081B3), `mem_ready` always 1.
  - States 0→1→2→4→0.
  - `alu_op` = 0000 in EXEC.
  - `reg_write` pulses exactly once, in cycle 4.
- **SUB and SRAI:** SUB (0x402081B3) gives `alu_op` 1000. SRAI (0x4020D193) gives `alu_op` 1101 with `alu_b_sel` 01.
- **LOAD wait states:** LW (0x0000A183) with `mem_ready` low for 3 cycles in MEM.
  - `mem_read` and `i_or_d` = 1 held for 4 cycles.
  - WB has `mem_to_reg` = 1.
  - Total 8 cycles.
- **Branches:**
  - BEQ with `zero` = 1: `pc_write` = 1, `pc_src` = 1 in EXEC, 3 cycles total.
  - BNE with `zero` = 1: `pc_write` = 0.
- **Faults:**
  - Opcode 0x7F: TRAP after DECODE, `trap_cause` 01.
  - `mem_ready` stuck low in FETCH with `MEM_WAIT_MAX` = 15: TRAP entered after 16 cycles, `trap_cause` 10.
  - Both cases: `rst_n` low for 1 cycle returns to state 0 with `trap` cleared.
- **Reset mid-instruction:** `rst_n` pulsed low during MEM of a STORE. No `mem_write` on the following cycle; FETCH resumes.
